elastic_pipe_reg: RTL and testbench
===================================

# elastic_pipe_reg

Parametrised elastic register pipeline: the successor to the single enable-gated D flip-flop used between datapath stages of the 16-bit fixed-point OCR accelerator. It moves LANES signed words through DEPTH register stages under a valid/ready handshake. It absorbs downstream stalls without losing data and collapses bubbles. A synchronous flush discards in-flight words. It sits between neuron-layer MAC/activation blocks wherever a fixed enable is insufficient to handle back-pressure.

## Interface
- DWIDTH, 16, width of one signed lane word
- LANES, 1, number of parallel lanes moved together as one beat
- DEPTH, 2, number of register stages (legal range 1..16)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all in-flight beats; data registers are kept
- in_valid  in  1  upstream beat present
- in_ready  out  1  pipeline accepts a beat this cycle
- in_data  in  LANES*DWIDTH  lane k at bits [k*DWIDTH +: DWIDTH], signed
- out_valid  out  1  last stage holds a beat
- out_ready  in  1  downstream accepts
- out_data  out  LANES*DWIDTH  contents of the last stage
- occupancy  out  $clog2(DEPTH+1)  number of valid stages; present only with ELASTIC_PIPE_OCC_EN

## Operation
- Each stage s (0 = input side, DEPTH-1 = output) holds v[s] and d[s].
- Stage advance condition: adv[s] = ~v[s] | adv[s+1].
- adv[DEPTH] = out_ready.
- in_ready = adv[0] & ~flush. This is combinational through the chain. No registered ready.
- On adv[s], stage s loads from stage s-1. Stage 0 loads from the input, with v[0] <= in_valid & in_ready.
- d[s] updates only when the incoming valid is 1. An empty stage does not capture garbage.
- When adv[s] = 0, v[s] and d[s] hold.
- Bubble collapse: any empty stage accepts new data even if downstream is stalled.
- Data is transferred bit-exact. There is no arithmetic, sign handling or saturation.
- flush: every v[s] <= 0 at the next edge. The input beat offered that cycle is not accepted (in_ready = 0). The output beat is considered not consumed, even if out_ready = 1.
- reset has priority over flush. All v and d go to 0.
- occupancy = popcount(v).

## Timing
- Reset values: out_valid = 0, out_data = 0, occupancy = 0.
- in_ready after reset = 1 (all stages empty). It is 0 only while flush is asserted.
- Latency: a beat accepted at edge N appears on out_valid/out_data after edge N+DEPTH-1 when unstalled. It is first visible in the cycle after edge N+DEPTH-1. With DEPTH=1, it is visible the cycle after acceptance.
- Throughput: 1 beat/cycle while out_ready = 1.
- Full: all v = 1 and out_ready = 0 gives in_ready = 0 in the same cycle.
- Full with out_ready = 1: in_ready = 1. An accept and a drain in the same cycle keep occupancy unchanged.
- Reset or flush mid-transfer: in-flight beats are lost. No partial beat is ever emitted.
- out_data is stable while out_valid = 1 and out_ready = 0.

## Configuration
- ELASTIC_PIPE_OCC_EN defined: the occupancy port and its popcount logic exist. Occupancy is registered-free and derived combinationally from the v bits.
- Not defined: the port is absent and no popcount logic is built. All other behaviour is identical.

## Structure
- Shared package accel_pkg:
  - DWIDTH_DEFAULT = 16
  - MAX_PIPE_DEPTH = 16
  - typedef for a signed DWIDTH word
  - clog2-based occupancy width helper
- Sub-module pipe_stage:
  - holds one valid bit and a LANES*DWIDTH data register
  - inputs: adv, upstream valid/data, flush
  - instantiated DEPTH times via generate
- Top level computes the adv chain and optional popcount.
- DEPTH is checked by an elaboration assertion (1..16).

## Test plan
- Streaming: DEPTH=3, LANES=2, out_ready = 1. Drive beats {0x0001,0xFFFF}, {0x0002,0x8000}, {0x0003,0x7FFF} on consecutive cycles. The same values appear in order with 3-cycle latency, and out_valid stays high for 3 consecutive cycles.
- Back-pressure: DEPTH=2. Drive 4 beats 0x0A..0x0D continuously with out_ready = 0. in_ready falls after 2 accepts. Release out_ready: output is 0x0A, 0x0B, 0x0C, 0x0D with no loss or duplication.
- Bubble collapse: DEPTH=3, out_ready = 0. Send one beat 0x55, idle 2 cycles, then send 0x66. Both are accepted, and occupancy = 2 with the macro on.
- Simultaneous accept/drain at full: DEPTH=2, full, in_valid = 1, out_ready = 1. in_ready = 1 and occupancy stays at 2 across 5 cycles.
- Flush: pipeline holding 0x11, 0x22 with flush = 1 and in_valid = 1 (data 0x33). Next cycle: out_valid = 0, occupancy = 0, and 0x33 never appears.
- Reset mid-stall: full pipeline with reset pulsed for 1 cycle. out_valid = 0, out_data = 0x0000 and in_ready = 1 on the following cycle.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the OCR accelerator datapath: word width, pipeline
// depth limit and the occupancy-width helper used by elastic_pipe_reg.
package accel_pkg;

    localparam int DWIDTH_DEFAULT = 16;
    localparam int MAX_PIPE_DEPTH = 16;

    typedef logic signed [DWIDTH_DEFAULT-1:0] word_t;

    // Bits needed to count 0..depth valid stages.
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: a valid bit plus a beat-wide data register that
// loads from upstream when the stage is allowed to advance.
module pipe_stage
    import accel_pkg::*;
#(
    parameter int WIDTH = DWIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             adv,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            // Flush drops the beat but leaves the data register untouched.
            valid <= 1'b0;
        end else if (adv) begin
            valid <= up_valid;
            if (up_valid) begin
                data <= up_data;
            end
        end
    end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Elastic register pipeline moving LANES signed words through DEPTH stages.
// Define ELASTIC_PIPE_OCC_EN to add the combinational occupancy output.
module elastic_pipe_reg
    import accel_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEFAULT,
    parameter int LANES  = 1,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DWIDTH-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DWIDTH-1:0]   out_data
`ifdef ELASTIC_PIPE_OCC_EN
    ,
    output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

    localparam int W = LANES * DWIDTH;

    if (DEPTH < 1 || DEPTH > MAX_PIPE_DEPTH) begin : g_bad_depth
        $error("elastic_pipe_reg: DEPTH must be in 1..%0d", MAX_PIPE_DEPTH);
    end

    logic [DEPTH-1:0] v;
    logic [W-1:0]     d [DEPTH];
    logic [DEPTH:0]   adv;
    logic             accept;

    // Handshake: a beat moves across a port on a rising edge exactly when
    // valid and ready are both 1 in that cycle; ready here is combinational
    // from out_ready through the advance chain, so empty stages always fill.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int s = DEPTH - 1; s >= 0; s--) begin
            adv[s] = ~v[s] | adv[s+1];
        end
    end

    assign in_ready = adv[0] & ~flush;
    assign accept   = in_valid & in_ready;

    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic         up_v;
        logic [W-1:0] up_d;

        if (s == 0) begin : g_head
            assign up_v = accept;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = v[s-1];
            assign up_d = d[s-1];
        end

        pipe_stage #(
            .WIDTH (W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .adv      (adv[s]),
            .up_valid (up_v),
            .up_data  (up_d),
            .valid    (v[s]),
            .data     (d[s])
        );
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

`ifdef ELASTIC_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    always_comb begin
        occupancy = '0;
        for (int s = 0; s < DEPTH; s++) begin
            occupancy = occupancy + OCC_W'(v[s]);
        end
    end
`endif

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: a DEPTH=2/LANES=1 and a DEPTH=3/LANES=2 instance
// checked every cycle against a positional queue model plus directed literals.
module tb_elastic_pipe_reg;

    localparam int D2 = 2;
    localparam int D3 = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        f2, iv2, ir2, ov2, or2;
    logic [15:0] id2, od2;
    logic        f3, iv3, ir3, ov3, or3;
    logic [31:0] id3, od3;
`ifdef ELASTIC_PIPE_OCC_EN
    logic [1:0]  occ2;
    logic [2:0]  occ3;
`endif

    elastic_pipe_reg #(.DWIDTH(16), .LANES(1), .DEPTH(D2)) u_dut2 (
        .clk       (clk),
        .reset     (reset),
        .flush     (f2),
        .in_valid  (iv2),
        .in_ready  (ir2),
        .in_data   (id2),
        .out_valid (ov2),
        .out_ready (or2),
        .out_data  (od2)
`ifdef ELASTIC_PIPE_OCC_EN
        ,
        .occupancy (occ2)
`endif
    );

    elastic_pipe_reg #(.DWIDTH(16), .LANES(2), .DEPTH(D3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .flush     (f3),
        .in_valid  (iv3),
        .in_ready  (ir3),
        .in_data   (id3),
        .out_valid (ov3),
        .out_ready (or3),
        .out_data  (od3)
`ifdef ELASTIC_PIPE_OCC_EN
        ,
        .occupancy (occ3)
`endif
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    // Model: ordered list of in-flight beats (oldest first) with their stage
    // positions; beats slide forward whenever the slot ahead is free.
    int n [2];
    int pos [2][16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic model_cycle(input int k, input int depth, input logic rst, input logic fl,
                               input logic iv, input logic ordy, input logic [31:0] idata,
                               input logic act_ir, input logic act_ov,
                               input logic [31:0] act_od, input int act_occ);
        bit          m_ov, m_ir, popped;
        int          lim, first;
        int          np [16];
        logic [31:0] front;
        if (rst) begin
            n[k] = 0;
            if (k == 0) exp_q0.delete(); else exp_q1.delete();
            return;
        end
        m_ov   = (n[k] > 0) && (pos[k][0] == depth - 1);
        popped = !fl && m_ov && ordy;
        first  = popped ? 1 : 0;
        lim    = depth;
        for (int i = first; i < n[k]; i++) begin
            np[i] = (pos[k][i] + 1 < lim) ? pos[k][i] + 1 : lim - 1;
            lim   = np[i];
        end
        m_ir = !fl && (lim > 0);

        chk($sformatf("dut%0d_in_ready", k), {31'b0, act_ir}, {31'b0, m_ir});
        chk($sformatf("dut%0d_out_valid", k), {31'b0, act_ov}, {31'b0, m_ov});
        if (m_ov) begin
            front = (k == 0) ? exp_q0[0] : exp_q1[0];
            chk($sformatf("dut%0d_out_data", k), act_od, front);
        end
        if (act_occ >= 0) begin
            chk($sformatf("dut%0d_occupancy", k), act_occ, n[k]);
        end

        if (fl) begin
            n[k] = 0;
            if (k == 0) exp_q0.delete(); else exp_q1.delete();
        end else begin
            for (int i = first; i < n[k]; i++) pos[k][i-first] = np[i];
            n[k] -= first;
            if (popped) begin
                if (k == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
            end
            if (iv && m_ir) begin
                pos[k][n[k]] = 0;
                n[k]++;
                if (k == 0) exp_q0.push_back(idata); else exp_q1.push_back(idata);
            end
        end
    endtask

    // Compare process: outputs are sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        int o2, o3;
`ifdef ELASTIC_PIPE_OCC_EN
        o2 = int'(occ2);
        o3 = int'(occ3);
`else
        o2 = -1;
        o3 = -1;
`endif
        model_cycle(0, D2, reset, f2, iv2, or2, {16'h0, id2}, ir2, ov2, {16'h0, od2}, o2);
        model_cycle(1, D3, reset, f3, iv3, or3, id3, ir3, ov3, od3, o3);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic occ_chk(input string name, input int k, input int req);
`ifdef ELASTIC_PIPE_OCC_EN
        chk(name, (k == 0) ? int'(occ2) : int'(occ3), req);
`else
        if (k < 0) $display("unused %s %0d", name, req);
`endif
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n[0] = 0; n[1] = 0;
        f2 = 0; iv2 = 0; or2 = 1; id2 = '0;
        f3 = 0; iv3 = 0; or3 = 1; id3 = '0;

        // Reset values
        repeat (2) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready2", {31'b0, ir2}, 32'd1);
        chk("rst_out_valid2", {31'b0, ov2}, 32'd0);
        chk("rst_out_data2", {16'h0, od2}, 32'h0);
        chk("rst_in_ready3", {31'b0, ir3}, 32'd1);
        chk("rst_out_data3", od3, 32'h0);
        occ_chk("rst_occ3", 1, 0);

        // Streaming, DEPTH=3, two lanes
        tick();
        iv3 = 1; id3 = 32'hFFFF_0001;
        tick();
        id3 = 32'h8000_0002;
        tick();
        id3 = 32'h7FFF_0003;
        tick();
        iv3 = 0;
        @(negedge clk);
        chk("stream_v0", {31'b0, ov3}, 32'd1);
        chk("stream_d0", od3, 32'hFFFF_0001);
        tick(); @(negedge clk);
        chk("stream_v1", {31'b0, ov3}, 32'd1);
        chk("stream_d1", od3, 32'h8000_0002);
        tick(); @(negedge clk);
        chk("stream_v2", {31'b0, ov3}, 32'd1);
        chk("stream_d2", od3, 32'h7FFF_0003);
        tick(); @(negedge clk);
        chk("stream_end", {31'b0, ov3}, 32'd0);

        // Back-pressure, DEPTH=2
        tick();
        or2 = 0; iv2 = 1; id2 = 16'h000A;
        @(negedge clk); chk("bp_ready_a", {31'b0, ir2}, 32'd1);
        tick();
        id2 = 16'h000B;
        @(negedge clk); chk("bp_ready_b", {31'b0, ir2}, 32'd1);
        tick();
        id2 = 16'h000C;
        @(negedge clk); chk("bp_full_ready", {31'b0, ir2}, 32'd0);
        occ_chk("bp_full_occ", 0, 2);
        tick();
        @(negedge clk);
        chk("bp_hold_ready", {31'b0, ir2}, 32'd0);
        chk("bp_hold_data", {16'h0, od2}, 32'h000A);
        tick();
        or2 = 1;
        @(negedge clk);
        chk("bp_drain_ready", {31'b0, ir2}, 32'd1);
        chk("bp_out_a", {16'h0, od2}, 32'h000A);
        tick();
        id2 = 16'h000D;
        @(negedge clk); chk("bp_out_b", {16'h0, od2}, 32'h000B);
        tick();
        iv2 = 0;
        @(negedge clk); chk("bp_out_c", {16'h0, od2}, 32'h000C);
        tick();
        @(negedge clk); chk("bp_out_d", {16'h0, od2}, 32'h000D);
        tick();
        @(negedge clk); chk("bp_empty", {31'b0, ov2}, 32'd0);

        // Bubble collapse, DEPTH=3 stalled
        or3 = 0; iv3 = 1; id3 = 32'h0000_0055;
        tick();
        iv3 = 0;
        repeat (2) tick();
        iv3 = 1; id3 = 32'h0000_0066;
        @(negedge clk); chk("bubble_ready", {31'b0, ir3}, 32'd1);
        tick();
        iv3 = 0;
        @(negedge clk);
        chk("bubble_out", od3, 32'h0000_0055);
        occ_chk("bubble_occ", 1, 2);
        or3 = 1;
        repeat (4) tick();
        @(negedge clk); chk("bubble_drained", {31'b0, ov3}, 32'd0);

        // Simultaneous accept/drain at full, DEPTH=2
        tick();
        or2 = 0; iv2 = 1; id2 = 16'h0021;
        tick();
        id2 = 16'h0022;
        tick();
        or2 = 1;
        for (int i = 0; i < 5; i++) begin
            id2 = 16'h0023 + 16'(i);
            @(negedge clk);
            chk($sformatf("full_ready_%0d", i), {31'b0, ir2}, 32'd1);
            occ_chk($sformatf("full_occ_%0d", i), 0, 2);
            tick();
        end
        iv2 = 0;
        repeat (3) tick();

        // Flush with an offered beat and out_ready high
        or2 = 0; iv2 = 1; id2 = 16'h0011;
        tick();
        id2 = 16'h0022;
        tick();
        f2 = 1; or2 = 1; id2 = 16'h0033;
        @(negedge clk); chk("flush_ready", {31'b0, ir2}, 32'd0);
        tick();
        f2 = 0; iv2 = 0;
        @(negedge clk);
        chk("flush_valid", {31'b0, ov2}, 32'd0);
        chk("flush_keeps_data", {16'h0, od2}, 32'h0011);
        occ_chk("flush_occ", 0, 0);
        repeat (3) tick();

        // Reset mid-stall
        or2 = 0; iv2 = 1; id2 = 16'h0044;
        tick();
        id2 = 16'h0045;
        tick();
        iv2 = 0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_valid", {31'b0, ov2}, 32'd0);
        chk("rst2_data", {16'h0, od2}, 32'h0);
        chk("rst2_ready", {31'b0, ir2}, 32'd1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
